// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 key event decoder.
package kbd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_DECODE
    } state_t;

    localparam logic [7:0] KC_EXT    = 8'hE0;
    localparam logic [7:0] KC_BRK    = 8'hF0;
    localparam logic [7:0] KC_LSHIFT = 8'h12;
    localparam logic [7:0] KC_RSHIFT = 8'h59;
    localparam logic [7:0] KC_CAPS   = 8'h58;

    function automatic logic is_lower_letter(input logic [7:0] a);
        return (a >= 8'h61) && (a <= 8'h7A);
    endfunction

endpackage

// File: rtl/keycode_to_ascii.sv
// Scan-code set 2 to ASCII lookup: lowercase letters, digits, space and enter; 0 otherwise.
module keycode_to_ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan-code event decoder: pops FIFO bytes, resolves E0/F0 prefixes, emits press/release events.
// Optional feature: define KBD_SHIFT_EN for shift/caps-lock aware ASCII.
module ps2_key_event
    import kbd_pkg::*;
#(
    parameter int HIST_DEPTH = 3,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic [7:0]              data,
    input  logic                    overflow,
    output logic                    nextdata_n,
    output logic                    ev_valid,
    output logic                    ev_break,
    output logic                    ev_ext,
    output logic [7:0]              ev_code,
    output logic [7:0]              ev_ascii,
    output logic                    key_held,
    output logic [CNT_W-1:0]        press_cnt,
    output logic [8*HIST_DEPTH-1:0] hist,
    output logic                    err
);

    state_t                  state_q, state_d;
    logic [7:0]              byte_q, byte_d;
    logic                    ext_q, ext_d, brk_q, brk_d;
    logic                    held_q, held_d, held_ext_q, held_ext_d;
    logic [7:0]              held_code_q, held_code_d;
    logic                    ev_valid_q, ev_valid_d, ev_break_q, ev_break_d, ev_ext_q, ev_ext_d;
    logic [7:0]              ev_code_q, ev_code_d, ev_ascii_q, ev_ascii_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [8*HIST_DEPTH-1:0] hist_q, hist_d, hist_shift;
    logic                    err_q, err_d;
    logic [7:0]              lut_ascii, press_ascii;
    logic                    is_repeat, is_shift;
`ifdef KBD_SHIFT_EN
    logic                    shift_q, shift_d, caps_q, caps_d;
`endif

    keycode_to_ascii u_lut (
        .code  (byte_q),
        .ascii (lut_ascii)
    );

    if (HIST_DEPTH > 1) begin : g_hist_multi
        assign hist_shift = {hist_q[8*HIST_DEPTH-9:0], byte_q};
    end else begin : g_hist_single
        assign hist_shift = byte_q;
    end

    assign is_repeat = held_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

`ifdef KBD_SHIFT_EN
    assign is_shift = !ext_q && ((byte_q == KC_LSHIFT) || (byte_q == KC_RSHIFT));
    always_comb begin
        press_ascii = lut_ascii;
        if (is_lower_letter(lut_ascii) && (shift_q ^ caps_q))
            press_ascii = lut_ascii - 8'h20;
    end
`else
    assign is_shift    = 1'b0;
    assign press_ascii = lut_ascii;
`endif

    // Decode runs on the S_WAIT -> S_DECODE edge so ev_valid is high during S_DECODE.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        ev_valid_d  = 1'b0;
        ev_break_d  = ev_break_q;
        ev_ext_d    = ev_ext_q;
        ev_code_d   = ev_code_q;
        ev_ascii_d  = ev_ascii_q;
        cnt_d       = cnt_q;
        hist_d      = hist_q;
        err_d       = err_q | overflow;
`ifdef KBD_SHIFT_EN
        shift_d     = shift_q;
        caps_d      = caps_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    byte_d  = data;
                    state_d = S_POP;
                end
            end
            S_POP: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_DECODE;
                if (byte_q == KC_EXT) begin
                    if (ext_q) err_d = 1'b1;
                    ext_d = 1'b1;
                end else if (byte_q == KC_BRK) begin
                    if (brk_q) err_d = 1'b1;
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    ev_valid_d = 1'b1;
                    ev_break_d = 1'b1;
                    ev_code_d  = byte_q;
                    ev_ext_d   = ext_q;
                    if (is_repeat) held_d = 1'b0;
`ifdef KBD_SHIFT_EN
                    if (is_shift) shift_d = 1'b0;
`endif
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (is_repeat) begin
                    ext_d = 1'b0;
                end else begin
                    ev_valid_d = 1'b1;
                    ev_break_d = 1'b0;
                    ev_code_d  = byte_q;
                    ev_ext_d   = ext_q;
                    ext_d      = 1'b0;
                    if (is_shift) begin
`ifdef KBD_SHIFT_EN
                        shift_d = 1'b1;
`endif
                    end else begin
`ifdef KBD_SHIFT_EN
                        if (!ext_q && (byte_q == KC_CAPS)) caps_d = ~caps_q;
`endif
                        held_d      = 1'b1;
                        held_code_d = byte_q;
                        held_ext_d  = ext_q;
                        cnt_d       = cnt_q + CNT_W'(1);
                        hist_d      = hist_shift;
                        ev_ascii_d  = ext_q ? 8'h00 : press_ascii;
                    end
                end
            end
            S_DECODE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_q      <= 8'h00;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_break_q  <= 1'b0;
            ev_ext_q    <= 1'b0;
            ev_code_q   <= 8'h00;
            ev_ascii_q  <= 8'h00;
            cnt_q       <= '0;
            hist_q      <= '0;
            err_q       <= 1'b0;
`ifdef KBD_SHIFT_EN
            shift_q     <= 1'b0;
            caps_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            ev_valid_q  <= ev_valid_d;
            ev_break_q  <= ev_break_d;
            ev_ext_q    <= ev_ext_d;
            ev_code_q   <= ev_code_d;
            ev_ascii_q  <= ev_ascii_d;
            cnt_q       <= cnt_d;
            hist_q      <= hist_d;
            err_q       <= err_d;
`ifdef KBD_SHIFT_EN
            shift_q     <= shift_d;
            caps_q      <= caps_d;
`endif
        end
    end

    assign nextdata_n = (state_q != S_POP);
    assign ev_valid   = ev_valid_q;
    assign ev_break   = ev_break_q;
    assign ev_ext     = ev_ext_q;
    assign ev_code    = ev_code_q;
    assign ev_ascii   = ev_ascii_q;
    assign key_held   = held_q;
    assign press_cnt  = cnt_q;
    assign hist       = hist_q;
    assign err        = err_q;

endmodule
